// File: rtl/cpu_defs_pkg.sv
// Shared CPU definitions: fetch state encodings and default memory/word geometry.
// Imported by the fetch sequencer and other CPU blocks.
package cpu_defs;

  localparam int unsigned ADDR_WIDTH  = 8;
  localparam int unsigned DATA_WIDTH  = 8;
  localparam int unsigned MEM_DEPTH   = 64;
  localparam int unsigned COUNT_WIDTH = 16;
  localparam logic [7:0]  HALT_OPCODE = 8'b1111_1111;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } fetch_state_e;

endpackage : cpu_defs

// File: rtl/fetch_sequencer.sv
// Program-counter sequencer: walks instruction memory, holds one fetched word for
// decode behind a valid/ready handshake, and handles start, redirect and halt.
module fetch_sequencer #(
  parameter int unsigned                  ADDR_WIDTH  = cpu_defs::ADDR_WIDTH,
  parameter int unsigned                  MEM_DEPTH   = cpu_defs::MEM_DEPTH,
  parameter int unsigned                  DATA_WIDTH  = cpu_defs::DATA_WIDTH,
  parameter logic [DATA_WIDTH-1:0]        HALT_OPCODE = cpu_defs::HALT_OPCODE,
  parameter int unsigned                  COUNT_WIDTH = cpu_defs::COUNT_WIDTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [ADDR_WIDTH-1:0]  start_addr,
  output logic [ADDR_WIDTH-1:0]  instruction_address,
  input  logic [DATA_WIDTH-1:0]  instruction_data,
  input  logic                   redirect_valid,
  input  logic [ADDR_WIDTH-1:0]  redirect_target,
  output logic [DATA_WIDTH-1:0]  instr,
  output logic [ADDR_WIDTH-1:0]  instr_pc,
  output logic                   instr_valid,
  input  logic                   instr_ready,
  output logic                   halted,
  output logic                   running,
  output logic [COUNT_WIDTH-1:0] fetch_count
);

  import cpu_defs::*;

  if ((MEM_DEPTH & (MEM_DEPTH - 1)) != 0 || MEM_DEPTH > (2 ** ADDR_WIDTH)) begin : g_bad_depth
    $error("MEM_DEPTH must be a power of two no larger than 2**ADDR_WIDTH");
  end

  // Clearing the upper PC bits keeps every address inside the populated memory.
  localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = ADDR_WIDTH'(MEM_DEPTH - 1);

  fetch_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0]   pc_q, pc_d;
  logic [DATA_WIDTH-1:0]   instr_q, instr_d;
  logic [ADDR_WIDTH-1:0]   instr_pc_q, instr_pc_d;
  logic                    instr_valid_q, instr_valid_d;
  logic [COUNT_WIDTH-1:0]  fetch_count_q, fetch_count_d;
  logic                    load;

  assign load = !instr_valid_q || instr_ready;

  // NOTE: every *_d gets its hold value first, so no path through the case leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    instr_valid_d = instr_valid_q;
    fetch_count_d = fetch_count_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          pc_d    = start_addr & ADDR_MASK;
          state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        if (redirect_valid) begin
          pc_d          = redirect_target & ADDR_MASK;
          instr_valid_d = 1'b0;
        end else if (load) begin
          instr_d       = instruction_data;
          instr_pc_d    = pc_q;
          instr_valid_d = 1'b1;
          if (fetch_count_q != {COUNT_WIDTH{1'b1}}) begin
            fetch_count_d = fetch_count_q + COUNT_WIDTH'(1);
          end
          // A halt word parks the PC on its own address.
          if (instruction_data == HALT_OPCODE) begin
            state_d = ST_HALTED;
          end else begin
            pc_d = (pc_q + ADDR_WIDTH'(1)) & ADDR_MASK;
          end
        end
      end

      ST_HALTED: begin
        if (start) begin
          pc_d          = start_addr & ADDR_MASK;
          state_d       = ST_RUN;
          instr_valid_d = 1'b0;
        end else if (instr_ready) begin
          instr_valid_d = 1'b0;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the
  // pre-edge values; the reset branch is asynchronous and active-high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      pc_q          <= '0;
      instr_q       <= '0;
      instr_pc_q    <= '0;
      instr_valid_q <= 1'b0;
      fetch_count_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      instr_valid_q <= instr_valid_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  assign instruction_address = pc_q;
  assign instr               = instr_q;
  assign instr_pc            = instr_pc_q;
  assign instr_valid         = instr_valid_q;
  assign fetch_count         = fetch_count_q;
  assign halted              = (state_q == ST_HALTED);
  assign running             = (state_q == ST_RUN);

endmodule : fetch_sequencer
